// File: rtl/mem_host_ctrl.sv
// mem_host_ctrl: host-side sequencer for the processor's external memory port.
// Streams a byte image into data memory through the processor's write phase,
// lets the program run until end_process (or an optional timeout), then reads
// a fixed result window back out as a valid/ready byte stream.
module mem_host_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int LOAD_LEN    = 16,
   parameter int DUMP_BASE   = 0,
   parameter int DUMP_LEN    = 16,
   parameter int RD_LAT      = 2,
   parameter int RUN_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              end_process,
   input  logic [DATA_W-1:0] dm_out,
   output logic [1:0]        status,
   output logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] data_addr_in,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

   // Counters need one extra bit so a full 2^ADDR_W transfer length fits.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
   localparam logic [CNT_W-1:0]  DUMP_LAST   = CNT_W'(DUMP_LEN - 1);
   localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);
   localparam logic [7:0]        RD_LAT_W    = 8'(RD_LAT);
   localparam logic [31:0]       TO_LAST     = (RUN_TIMEOUT == 0) ? 32'd0 : 32'(RUN_TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_WRITE = 2'b10;
   localparam logic [1:0] ST_HOLD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DRAIN, S_RUN, S_DWAIT, S_DOUT, S_DONE
   } state_t;

   state_t            r_state;
   logic [1:0]        r_status;
   logic [DATA_W-1:0] r_data_in;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_base;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_idx;
   logic [31:0]       r_run_cnt;
   logic [1:0]        r_drain;
   logic [7:0]        r_wait;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_busy;
   logic              r_done;
   logic              r_timeout_err;

   logic w_load_hs;
   logic w_out_hs;

   // Address arithmetic wraps modulo 2^ADDR_W by truncation.
   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] ofs);
      return base + ofs;
   endfunction

   assign w_load_hs = in_valid & r_in_ready;
   assign w_out_hs  = r_out_valid & out_ready;

   // Job sequencer: every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_status      <= ST_IDLE;
         r_data_in     <= '0;
         r_addr        <= '0;
         r_base        <= '0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_run_cnt     <= '0;
         r_drain       <= '0;
         r_wait        <= '0;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base        <= load_base;
                  r_cnt         <= '0;
                  r_idx         <= '0;
                  r_run_cnt     <= '0;
                  r_drain       <= '0;
                  r_wait        <= '0;
                  r_timeout_err <= 1'b0;
                  r_in_ready    <= 1'b1;
                  r_busy        <= 1'b1;
                  r_status      <= ST_HOLD;
                  r_state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               // A write phase only follows an accepted byte; idle cycles hold.
               if (w_load_hs) begin
                  r_status  <= ST_WRITE;
                  r_data_in <= in_data;
                  r_addr    <= wrap_addr(r_base, r_cnt[ADDR_W-1:0]);
                  r_cnt     <= r_cnt + CNT_W'(1);
                  if (r_cnt == LOAD_LAST) begin
                     r_in_ready <= 1'b0;
                     r_drain    <= '0;
                     r_state    <= S_DRAIN;
                  end
               end else begin
                  r_status <= ST_HOLD;
               end
            end
            S_DRAIN: begin
               // Two hold cycles let the last write settle before RUN.
               if (r_drain == 2'd2) begin
                  r_status  <= ST_RUN;
                  r_run_cnt <= '0;
                  r_state   <= S_RUN;
               end else begin
                  r_status <= ST_HOLD;
                  r_drain  <= r_drain + 2'd1;
               end
            end
            S_RUN: begin
               if (end_process) begin
                  r_status <= ST_HOLD;
                  r_addr   <= wrap_addr(DUMP_BASE_A, r_idx[ADDR_W-1:0]);
                  r_wait   <= '0;
                  r_state  <= S_DWAIT;
               end else if ((RUN_TIMEOUT != 0) && (r_run_cnt == TO_LAST)) begin
                  r_timeout_err <= 1'b1;
                  r_status      <= ST_IDLE;
                  r_done        <= 1'b1;
                  r_state       <= S_DONE;
               end else begin
                  r_run_cnt <= r_run_cnt + 32'd1;
               end
            end
            S_DWAIT: begin
               // Address has been stable for RD_LAT cycles: dm_out is valid now.
               if (r_wait == RD_LAT_W) begin
                  r_out_data  <= dm_out;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DOUT;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_DOUT: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_idx       <= r_idx + CNT_W'(1);
                  if (r_idx == DUMP_LAST) begin
                     r_status <= ST_IDLE;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_addr  <= wrap_addr(DUMP_BASE_A, r_idx[ADDR_W-1:0] + ADDR_W'(1));
                     r_wait  <= '0;
                     r_state <= S_DWAIT;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign status       = r_status;
   assign data_in      = r_data_in;
   assign data_addr_in = r_addr;
   assign busy         = r_busy;
   assign done         = r_done;
   assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mem_host_ctrl.sv
// tb_mem_host_ctrl: table-driven job vectors plus a reset-mid-dump sequence.
// A small memory model stands in for the processor's data memory.
module tb_mem_host_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] load_base;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        end_process;
   logic [7:0]  dm_out;
   logic [1:0]  status;
   logic [7:0]  data_in;
   logic [15:0] data_addr_in;
   logic        busy;
   logic        done;
   logic        timeout_err;

   mem_host_ctrl #(
      .ADDR_W(16), .DATA_W(8), .LOAD_LEN(4), .DUMP_BASE(16'h0012),
      .DUMP_LEN(4), .RD_LAT(2), .RUN_TIMEOUT(50)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .load_base(load_base),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .end_process(end_process), .dm_out(dm_out), .status(status),
      .data_in(data_in), .data_addr_in(data_addr_in), .busy(busy),
      .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Data memory model: seeded 0x55+addr, written on status 10, read latency 2.
   logic [7:0] mem [0:65535];
   logic [7:0] rd_p1;
   logic       seed_req = 1'b0;
   always @(posedge clk) begin
      if (seed_req) begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'(i + 32'h55);
      end else if (status == 2'b10) begin
         mem[data_addr_in] <= data_in;
      end
      rd_p1  <= mem[data_addr_in];
      dm_out <= rd_p1;
   end

   // Observation, sampled on the falling edge.
   int          cyc = 0, wr_n = 0, run_n = 0, done_n = 0, ov_n = 0, dn = 0;
   int          hold_bad = 0, stab_bad = 0, irdy_bad = 0, run_start = 0;
   logic [15:0] wr_addr [0:255];
   logic [7:0]  wr_data [0:255];
   int          wr_cyc  [0:255];
   logic [7:0]  dump    [0:255];
   logic [1:0]  prev_status = 2'b00;
   logic [15:0] prev_addr = '0;
   logic [7:0]  prev_din = '0, prev_odata = '0;
   logic        prev_ov = 1'b0, prev_ordy = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (status == 2'b10) begin
         wr_addr[wr_n] <= data_addr_in;
         wr_data[wr_n] <= data_in;
         wr_cyc[wr_n]  <= cyc;
         wr_n          <= wr_n + 1;
      end
      if (status == 2'b11 && prev_status == 2'b10 &&
          (data_addr_in !== prev_addr || data_in !== prev_din))
         hold_bad <= hold_bad + 1;
      if (status == 2'b01) begin
         run_n <= run_n + 1;
         if (in_ready) irdy_bad <= irdy_bad + 1;
         if (prev_status != 2'b01) run_start <= cyc;
      end
      if (done) done_n <= done_n + 1;
      if (out_valid) begin
         ov_n <= ov_n + 1;
         if (prev_ov && !prev_ordy &&
             (out_data !== prev_odata || data_addr_in !== prev_addr))
            stab_bad <= stab_bad + 1;
         if (out_ready) begin
            dump[dn] <= out_data;
            dn       <= dn + 1;
         end
      end
      prev_status <= status;
      prev_addr   <= data_addr_in;
      prev_din    <= data_in;
      prev_odata  <= out_data;
      prev_ov     <= out_valid;
      prev_ordy   <= out_ready;
   end

   typedef struct {
      logic [15:0] base;
      logic [31:0] data;      // byte 0 in the top bits
      int          gap;       // idle cycles between bytes
      int          ep;        // RUN cycles before end_process; -1 never; -2 already high
      int          stall;     // cycles out_ready stays low per result byte
      logic [63:0] exp_addr;  // four write addresses, first in the top bits
      logic [31:0] exp_dump;  // four result bytes, first in the top bits
      int          exp_run;
      logic        exp_to;
   } vec_t;
   vec_t vec [6];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic expire(input string nm);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic seed_mem();
      seed_req = 1'b1;
      step();
      seed_req = 1'b0;
   endtask

   task automatic drive_load(input vec_t t);
      int k;
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1;
         in_data  = t.data[31-8*b -: 8];
         k = 0;
         while (!in_ready && k < 100) begin
            step();
            k++;
         end
         if (k >= 100) begin
            expire("load_handshake");
            in_valid = 1'b0;
            return;
         end
         step();
         if (b < 3) begin
            in_valid = 1'b0;
            for (int g = 0; g < t.gap; g++) begin
               start = (g == 0);   // a start outside IDLE must be ignored
               step();
               start = 1'b0;
            end
         end
      end
      // Stray bytes after the load must not produce writes.
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (4) step();
      in_valid = 1'b0;
   endtask

   task automatic drive_ep(input vec_t t);
      int k;
      if (t.ep == -1) return;
      k = 0;
      while (status !== 2'b01 && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) begin
         expire("run_entry");
         end_process = 1'b0;
         return;
      end
      if (t.ep >= 0) begin
         repeat (t.ep) step();
         end_process = 1'b1;
      end
      k = 0;
      while (status === 2'b01 && k < 100) begin
         step();
         k++;
      end
      end_process = 1'b0;
   endtask

   task automatic drive_sink(input vec_t t);
      int k;
      if (t.exp_to) return;
      for (int b = 0; b < 4; b++) begin
         k = 0;
         while (!out_valid && k < 500) begin
            step();
            k++;
         end
         if (k >= 500) begin
            expire("out_valid_wait");
            return;
         end
         repeat (t.stall) step();
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 1000) begin
         step();
         k++;
      end
      if (busy) expire("job_end");
   endtask

   task automatic run_job(input int v);
      vec_t  t;
      int    w0, r0, d0, o0, n0, h0, s0, i0, wn;
      string p;
      t  = vec[v];
      p  = $sformatf("job%0d", v);
      seed_mem();
      w0 = wr_n; r0 = run_n; d0 = done_n; o0 = ov_n; n0 = dn;
      h0 = hold_bad; s0 = stab_bad; i0 = irdy_bad;
      end_process = (t.ep == -2);
      load_base = t.base;
      start     = 1'b1;
      step();
      start     = 1'b0;
      load_base = 16'hDEAD;
      chk({p, "_tmo_clear"}, 32'(timeout_err), 32'd0);
      chk({p, "_busy"}, 32'(busy), 32'd1);
      chk({p, "_in_ready"}, 32'(in_ready), 32'd1);
      fork
         drive_load(t);
         drive_ep(t);
         drive_sink(t);
      join
      wait_idle();
      repeat (3) step();
      wn = wr_n - w0;
      chk({p, "_wr_count"}, wn, 4);
      if (wn == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_wr_addr%0d", p, i), 32'(wr_addr[w0+i]), 32'(t.exp_addr[63-16*i -: 16]));
            chk($sformatf("%s_wr_data%0d", p, i), 32'(wr_data[w0+i]), 32'(t.data[31-8*i -: 8]));
         end
         chk({p, "_wr_span"}, wr_cyc[w0+3] - wr_cyc[w0], 3 * (t.gap + 1));
         chk({p, "_drain"}, run_start - wr_cyc[w0+3], 3);
      end
      chk({p, "_run_cycles"}, run_n - r0, t.exp_run);
      chk({p, "_done_pulses"}, done_n - d0, 1);
      chk({p, "_timeout_err"}, 32'(timeout_err), 32'(t.exp_to));
      if (t.exp_to) begin
         chk({p, "_no_out_valid"}, ov_n - o0, 0);
      end else begin
         chk({p, "_dump_count"}, dn - n0, 4);
         if (dn - n0 == 4)
            for (int i = 0; i < 4; i++)
               chk($sformatf("%s_dump%0d", p, i), 32'(dump[n0+i]), 32'(t.exp_dump[31-8*i -: 8]));
      end
      chk({p, "_hold"}, hold_bad - h0, 0);
      chk({p, "_out_stable"}, stab_bad - s0, 0);
      chk({p, "_in_ready_run"}, irdy_bad - i0, 0);
      chk({p, "_idle_status"}, 32'(status), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t r;
      int   k;
      vec[0] = '{16'h0010, 32'hA1B2C3D4, 0, 20, 0, 64'h0010_0011_0012_0013, 32'hC3D4696A, 21, 1'b0};
      vec[1] = '{16'h0100, 32'h11223344, 2,  5, 0, 64'h0100_0101_0102_0103, 32'h6768696A,  6, 1'b0};
      vec[2] = '{16'h0012, 32'h01020304, 0,  3, 5, 64'h0012_0013_0014_0015, 32'h01020304,  4, 1'b0};
      vec[3] = '{16'h0030, 32'h5A5B5C5D, 0, -1, 0, 64'h0030_0031_0032_0033, 32'h00000000, 50, 1'b1};
      vec[4] = '{16'h0014, 32'hE1E2E3E4, 0, -2, 1, 64'h0014_0015_0016_0017, 32'h6768E1E2,  1, 1'b0};
      vec[5] = '{16'hFFFE, 32'h9A9B9C9D, 1,  0, 0, 64'hFFFE_FFFF_0000_0001, 32'h6768696A,  1, 1'b0};

      rst = 1'b1; start = 1'b0; load_base = '0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; end_process = 1'b0;
      repeat (3) step();
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_addr", 32'(data_addr_in), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;
      step();

      for (int v = 0; v < 6; v++) run_job(v);

      // Reset asserted while a result byte is waiting on the sink.
      seed_mem();
      r = vec[0];
      r.ep = 0;
      load_base = 16'h0010;
      start = 1'b1;
      step();
      start = 1'b0;
      fork
         drive_load(r);
         drive_ep(r);
      join
      k = 0;
      while (!out_valid && k < 200) begin
         step();
         k++;
      end
      if (!out_valid) expire("mid_dump_out_valid");
      #2 rst = 1'b1;
      #1;
      chk("midrst_status", 32'(status), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      step();
      run_job(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_host_ctrl.md
Name: mem_host_ctrl

Overview:
- Host-side sequencer that drives the processor's external memory-access interface (status, data_in, data_addr_in) and watches end_process.
- Sequence: streams a data image into data memory through the processor's load path, runs the program, then reads the result window back out as a byte stream.
- Sits between the testbench/host link and the processor top level. It is the initiator of every processor status phase.

Parameters:
- ADDR_W, 16, data memory address width; matches data_addr_in.
- DATA_W, 8, data memory word width; matches data_in and dm_out.
- LOAD_LEN, 16, number of bytes accepted and written in LOAD (1..2^ADDR_W).
- DUMP_BASE, 0, first data memory address read back in DUMP.
- DUMP_LEN, 16, number of bytes read back (1..2^ADDR_W).
- RD_LAT, 2, cycles from data_addr_in driven (status 11) to dm_out valid.
- RUN_TIMEOUT, 0, maximum RUN cycles before abort; 0 disables the timeout.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a job when in IDLE, ignored otherwise.
- load_base, input, ADDR_W, first LOAD address; sampled on accepted start.
- in_valid, input, 1, load byte valid.
- in_data, input, DATA_W, load byte.
- in_ready, output, 1, load byte accepted when in_valid and in_ready.
- out_valid, output, 1, result byte valid.
- out_data, output, DATA_W, result byte.
- out_ready, input, 1, sink accepts the result byte.
- end_process, input, 1, processor program finished (level).
- dm_out, input, DATA_W, data memory read data.
- status, output, 2, processor phase: 00 idle, 01 run, 10 write, 11 read/hold.
- data_in, output, DATA_W, byte to be written through the processor.
- data_addr_in, output, ADDR_W, memory address for write or read.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a job completes.
- timeout_err, output, 1, sticky; set on RUN timeout, cleared on accepted start.

Behaviour:
- Reset (async): state=IDLE; status=00; data_in=0; data_addr_in=0; in_ready=0; out_valid=0; out_data=0; busy=0; done=0; timeout_err=0; all counters 0.
- All outputs are registered.
- IDLE: status=00. On start, latch load_base, clear the counters and timeout_err, then go to LOAD.
- LOAD:
  - in_ready=1 while load count < LOAD_LEN.
  - On each handshake, next cycle: status=10, data_in=in_data, data_addr_in=load_base+count (wraps mod 2^ADDR_W), count++.
  - Cycles without a handshake: status=11 with addresses/data held, so no write is issued.
  - Exactly one status=10 cycle per byte; back-to-back bytes give consecutive 10 cycles.
  - After byte LOAD_LEN: in_ready=0 that same cycle, then 2 drain cycles at status=11, then go to RUN.
- RUN:
  - status=01; in_ready=0.
  - On end_process=1 (sampled synchronously), go to DUMP next cycle.
  - If RUN_TIMEOUT≠0 and the run counter reaches RUN_TIMEOUT: set timeout_err, skip DUMP, go to DONE.
  - If end_process is already high on RUN entry: exactly one RUN cycle.
- DUMP:
  - status=11; one read outstanding at a time.
  - ISSUE: data_addr_in = DUMP_BASE + idx (wraps).
  - WAIT: RD_LAT cycles, then capture dm_out into out_data and assert out_valid.
  - out_valid and out_data are held until out_ready; on handshake drop out_valid and idx++.
  - After byte DUMP_LEN, go to DONE; otherwise issue the next read the following cycle.
- DONE: status=00; done=1 for one cycle; go to IDLE.
- Boundary and interaction rules:
  - start outside IDLE is ignored.
  - in_valid outside LOAD is ignored (in_ready=0).
  - end_process outside RUN is ignored.
  - out_ready without out_valid has no effect.
- rst asserted mid-job: immediate return to reset values, status=00. No partial write completes from this block's side.

Test Plan:
- Basic load, run, dump:
  - Stimulus: LOAD_LEN=4, load_base=0x0010, bytes 0xA1,0xB2,0xC3,0xD4 back-to-back.
  - Required: four consecutive status=10 cycles at addresses 0x10..0x13; 2 drain cycles at 11; status=01.
  - Then end_process after 20 cycles; DUMP reads a memory model seeded 0x55+addr; out bytes match; done pulses once.
- Gapped input: in_valid toggles 1,0,0,1.
  - Required: status=11 during gaps, addresses held, byte count correct, no extra status=10 cycles.
- Sink backpressure: out_ready low 5 cycles per byte.
  - Required: out_data stable while out_valid; no byte dropped or duplicated; data_addr_in does not advance before the handshake.
- Timeout: RUN_TIMEOUT=50, end_process never asserted.
  - Required: exactly 50 RUN cycles; timeout_err=1; no out_valid; done pulse.
  - A following start clears timeout_err.
- Address wrap: load_base=0xFFFE, LOAD_LEN=4.
  - Required: write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-DUMP: assert rst while out_valid=1.
  - Required: same-cycle async clear: status=00, out_valid=0, busy=0.
  - A subsequent start runs a full job correctly.
